fb_mem_arbiter: RTL and testbench

Memory-side arbiter that drains the framebuffer's two command FIFOs and executes the commands on a single-port 16-bit word memory. Single-word writes and reads come from the 41-bit command FIFO; 8-word burst reads come from the 32-bit burst command FIFO. Read results return to the single-word reader FIFO, and packed 128-bit burst data returns to the burst reader FIFO. The block sits between the framebuffer's FIFOs and the external memory controller.

---
 rtl/fb_mem_pkg.sv | 32 +++
 rtl/fb_burst_packer.sv | 42 ++++
 rtl/fb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_mem_pkg.sv
// fb_mem_pkg
//   Shared definitions for the framebuffer memory-side arbiter: FSM state
//   encoding, command field positions and burst geometry. The framebuffer
//   side uses the same constants to build commands, so keep them in sync.
package fb_mem_pkg;

    // Encoding is visible on dbg_state_o; keep values stable.
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_ISSUE_BURST = 4'd1,
        ST_COLLECT     = 4'd2,
        ST_PUSH_BURST  = 4'd3,
        ST_ISSUE_WR    = 4'd4,
        ST_ISSUE_RD    = 4'd5,
        ST_WAIT_RD     = 4'd6,
        ST_PUSH_RD     = 4'd7
    } fb_mem_state_t;

    // Single command layout: {wr[40], addr[39:16], data[15:0]}
    localparam int CMD_W        = 41;
    localparam int CMD_WR_BIT   = 40;
    localparam int CMD_ADDR_MSB = 39;
    localparam int CMD_ADDR_LSB = 16;

    localparam int ADDR_W       = 24;
    localparam int WORD_W       = 16;

    localparam int BURST_WORDS  = 8;
    localparam int BURST_BITS   = 128;
    localparam int BURST_CNT_W  = $clog2(BURST_WORDS);

endpackage

// File: rtl/fb_burst_packer.sv
// fb_burst_packer
//   Collects BURST_WORDS 16-bit read words into one BURST_BITS vector.
//   Words shift in from the bottom, so the first word ends up in the top
//   slot [127:112] and the last word in [15:0].
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : restart the word count (start of a new burst)
//   shift       : accept 'word' this cycle
//   word        : incoming read word
//   data        : packed burst vector (registered)
//   done        : high in the cycle the final word of a burst is shifted
module fb_burst_packer
    import fb_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift,
    input  logic [WORD_W-1:0]     word,
    output logic [BURST_BITS-1:0] data,
    output logic                  done
);

    logic [BURST_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            data <= '0;
        end else if (clear) begin
            cnt  <= '0;
        end else if (shift) begin
            // Counter is exactly log2(BURST_WORDS) wide, so it wraps to 0
            // on the last word and is ready for the next burst.
            cnt  <= cnt + 1'b1;
            data <= {data[BURST_BITS-WORD_W-1:0], word};
        end
    end

    assign done = shift && (cnt == BURST_CNT_W'(BURST_WORDS - 1));

endmodule

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//   Drains the framebuffer's single-command FIFO (word writes/reads) and
//   burst-command FIFO (8-word reads) onto a single-port 16-bit memory.
//   One memory command is outstanding at a time. Bursts win arbitration
//   unless the optional fairness feature is compiled in.
//
//   Optional feature macro: FB_MEM_ARB_FAIR_EN
//     When defined, a saturating streak counter limits consecutive burst
//     grants to STARVE_LIMIT while a single command is waiting.
//
// Ports:
//   clk_pix, reset_i              : clock, asynchronous active-high reset
//   cmd_q_i/cmd_deq_o/cmd_empty_i : single command FIFO (FWFT)
//   burst_cmd_q_i/_deq_o/_empty_i : burst command FIFO (FWFT)
//   rd_d_o/rd_enq_o/rd_full_i     : single read result FIFO
//   rd_burst_d_o/_enq_o/_full_i   : packed burst result FIFO
//   mem_*                         : memory controller command/response
//   protocol_err_o                : pulse on read data with no read pending
//   dbg_state_o                   : current FSM state
module fb_mem_arbiter
    import fb_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_pix,
    input  logic                  reset_i,

    input  logic [CMD_W-1:0]      cmd_q_i,
    output logic                  cmd_deq_o,
    input  logic                  cmd_empty_i,

    input  logic [31:0]           burst_cmd_q_i,
    output logic                  burst_cmd_deq_o,
    input  logic                  burst_cmd_empty_i,

    output logic [WORD_W-1:0]     rd_d_o,
    output logic                  rd_enq_o,
    input  logic                  rd_full_i,

    output logic [BURST_BITS-1:0] rd_burst_d_o,
    output logic                  rd_burst_enq_o,
    input  logic                  rd_burst_full_i,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic                  mem_burst_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [WORD_W-1:0]     mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_W-1:0]     mem_rdata_i,

    output logic                  protocol_err_o,
    output logic [3:0]            dbg_state_o
);

    if (STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("fb_mem_arbiter: STARVE_LIMIT must be >= 1");
    end

    fb_mem_state_t state;

    // Upper byte of the burst command is reserved (always zero).
    logic unused_burst_hi;
    assign unused_burst_hi = ^burst_cmd_q_i[31:ADDR_W];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic burst_ok;
    logic single_ok;
    logic pick_single;
    logic pick_burst;

    // Burst result space is checked up front: this block is the only
    // producer, so the slot stays free until PUSH_BURST.
    assign burst_ok  = !burst_cmd_empty_i && !rd_burst_full_i;
    // A read blocked by a full reader FIFO is left in its FIFO.
    assign single_ok = !cmd_empty_i && (cmd_q_i[CMD_WR_BIT] || !rd_full_i);

`ifdef FB_MEM_ARB_FAIR_EN
    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak;
    logic                starved;

    assign starved     = (streak >= STREAK_MAX);
    assign pick_single = single_ok && (!burst_ok || starved);
    assign pick_burst  = burst_ok && !pick_single;

    always_ff @(posedge clk_pix or posedge reset_i) begin
        if (reset_i) begin
            streak <= '0;
        end else if ((state == ST_IDLE && pick_single) || cmd_empty_i) begin
            streak <= '0;
        end else if (state == ST_IDLE && pick_burst && streak != STREAK_MAX) begin
            streak <= streak + 1'b1;
        end
    end
`else
    assign pick_single = single_ok && !burst_ok;
    assign pick_burst  = burst_ok;
`endif

    // ------------------------------------------------------------------
    // Burst packing
    // ------------------------------------------------------------------
    logic pk_clear;
    logic pk_shift;
    logic pk_done;

    assign pk_clear = (state == ST_ISSUE_BURST) && mem_ready_i;
    assign pk_shift = (state == ST_COLLECT) && mem_rvalid_i;

    fb_burst_packer u_packer (
        .clk   (clk_pix),
        .rst   (reset_i),
        .clear (pk_clear),
        .shift (pk_shift),
        .word  (mem_rdata_i),
        .data  (rd_burst_d_o),
        .done  (pk_done)
    );

    // ------------------------------------------------------------------
    // Control FSM, all outputs registered
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pix or posedge reset_i) begin
        if (reset_i) begin
            state           <= ST_IDLE;
            cmd_deq_o       <= 1'b0;
            burst_cmd_deq_o <= 1'b0;
            rd_d_o          <= '0;
            rd_enq_o        <= 1'b0;
            rd_burst_enq_o  <= 1'b0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_burst_o     <= 1'b0;
            mem_addr_o      <= '0;
            mem_wdata_o     <= '0;
            protocol_err_o  <= 1'b0;
        end else begin
            cmd_deq_o       <= 1'b0;
            burst_cmd_deq_o <= 1'b0;
            rd_enq_o        <= 1'b0;
            rd_burst_enq_o  <= 1'b0;
            // Read data is only consumed in COLLECT/WAIT_RD; anything else
            // (including data racing an ISSUE handshake) is dropped.
            protocol_err_o  <= mem_rvalid_i &&
                               (state != ST_COLLECT) && (state != ST_WAIT_RD);

            case (state)
                ST_IDLE: begin
                    if (pick_burst) begin
                        burst_cmd_deq_o <= 1'b1;
                        mem_req_o       <= 1'b1;
                        mem_we_o        <= 1'b0;
                        mem_burst_o     <= 1'b1;
                        mem_addr_o      <= burst_cmd_q_i[ADDR_W-1:0];
                        state           <= ST_ISSUE_BURST;
                    end else if (pick_single) begin
                        cmd_deq_o   <= 1'b1;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= cmd_q_i[CMD_WR_BIT];
                        mem_burst_o <= 1'b0;
                        mem_addr_o  <= cmd_q_i[CMD_ADDR_MSB:CMD_ADDR_LSB];
                        if (cmd_q_i[CMD_WR_BIT]) begin
                            mem_wdata_o <= cmd_q_i[WORD_W-1:0];
                            state       <= ST_ISSUE_WR;
                        end else begin
                            state       <= ST_ISSUE_RD;
                        end
                    end
                end

                ST_ISSUE_BURST: begin
                    if (mem_ready_i) begin
                        mem_req_o   <= 1'b0;
                        mem_burst_o <= 1'b0;
                        state       <= ST_COLLECT;
                    end
                end

                ST_ISSUE_WR: begin
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                ST_ISSUE_RD: begin
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        state     <= ST_WAIT_RD;
                    end
                end

                ST_COLLECT: begin
                    if (pk_done) begin
                        rd_burst_enq_o <= 1'b1;
                        state          <= ST_PUSH_BURST;
                    end
                end

                ST_PUSH_BURST: state <= ST_IDLE;

                ST_WAIT_RD: begin
                    if (mem_rvalid_i) begin
                        rd_d_o   <= mem_rdata_i;
                        rd_enq_o <= 1'b1;
                        state    <= ST_PUSH_RD;
                    end
                end

                ST_PUSH_RD: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state_o = state;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter
//   Directed bench for fb_mem_arbiter. The two command FIFOs are modelled
//   as queues popped on the DUT's deq pulses; all driving and sampling is
//   done on the falling clock edge. Expected values are hand-derived.
//   Compile with +define+FB_MEM_ARB_FAIR_EN to check the fair ordering.
module tb_fb_mem_arbiter;

    logic          clk_pix = 1'b0;
    logic          reset_i;
    logic [40:0]   cmd_q_i;
    logic          cmd_deq_o;
    logic          cmd_empty_i;
    logic [31:0]   burst_cmd_q_i;
    logic          burst_cmd_deq_o;
    logic          burst_cmd_empty_i;
    logic [15:0]   rd_d_o;
    logic          rd_enq_o;
    logic          rd_full_i;
    logic [127:0]  rd_burst_d_o;
    logic          rd_burst_enq_o;
    logic          rd_burst_full_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic          mem_burst_o;
    logic [23:0]   mem_addr_o;
    logic [15:0]   mem_wdata_o;
    logic          mem_ready_i;
    logic          mem_rvalid_i;
    logic [15:0]   mem_rdata_i;
    logic          protocol_err_o;
    logic [3:0]    dbg_state_o;

    fb_mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk_pix           (clk_pix),
        .reset_i           (reset_i),
        .cmd_q_i           (cmd_q_i),
        .cmd_deq_o         (cmd_deq_o),
        .cmd_empty_i       (cmd_empty_i),
        .burst_cmd_q_i     (burst_cmd_q_i),
        .burst_cmd_deq_o   (burst_cmd_deq_o),
        .burst_cmd_empty_i (burst_cmd_empty_i),
        .rd_d_o            (rd_d_o),
        .rd_enq_o          (rd_enq_o),
        .rd_full_i         (rd_full_i),
        .rd_burst_d_o      (rd_burst_d_o),
        .rd_burst_enq_o    (rd_burst_enq_o),
        .rd_burst_full_i   (rd_burst_full_i),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_burst_o       (mem_burst_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_ready_i       (mem_ready_i),
        .mem_rvalid_i      (mem_rvalid_i),
        .mem_rdata_i       (mem_rdata_i),
        .protocol_err_o    (protocol_err_o),
        .dbg_state_o       (dbg_state_o)
    );

    always #5 clk_pix = ~clk_pix;

    int checks = 0;
    int errors = 0;

    logic [40:0] cq[$];
    logic [23:0] bq[$];
    logic [25:0] issue_log[$];   // {we, burst, addr} per accepted command
    int          n_rd_enq = 0;
    int          n_b_enq  = 0;
    int          n_perr   = 0;
    logic        auto_mem = 1'b0;
    logic [15:0] auto_word = 16'h0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifos();
        cmd_empty_i       = (cq.size() == 0);
        cmd_q_i           = (cq.size() != 0) ? cq[0] : 41'd0;
        burst_cmd_empty_i = (bq.size() == 0);
        burst_cmd_q_i     = (bq.size() != 0) ? {8'd0, bq[0]} : 32'd0;
    endtask

    // Advance to the next falling edge and account for what the DUT did.
    task automatic tick();
        @(negedge clk_pix);
        if (cmd_deq_o && cq.size() != 0)       void'(cq.pop_front());
        if (burst_cmd_deq_o && bq.size() != 0) void'(bq.pop_front());
        if (rd_enq_o)       n_rd_enq++;
        if (rd_burst_enq_o) n_b_enq++;
        if (protocol_err_o) n_perr++;
        if (mem_req_o && mem_ready_i) issue_log.push_back({mem_we_o, mem_burst_o, mem_addr_o});
        if (auto_mem) begin
            if (dbg_state_o == 4'd2 || dbg_state_o == 4'd6) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = auto_word;
                auto_word    = auto_word + 16'd1;
            end else begin
                mem_rvalid_i = 1'b0;
            end
        end
        drive_fifos();
    endtask

    task automatic feed(input logic [15:0] w);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = w;
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        int b0, e0;
        reset_i         = 1'b1;
        rd_full_i       = 1'b0;
        rd_burst_full_i = 1'b0;
        mem_ready_i     = 1'b1;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = 16'h0;
        drive_fifos();

        // ---- reset state ----
        tick(); tick();
        chk("rst_req",   mem_req_o, 1'b0);
        chk("rst_deq",   {cmd_deq_o, burst_cmd_deq_o, rd_enq_o, rd_burst_enq_o}, 4'b0);
        chk("rst_state", dbg_state_o, 4'd0);
        chk("rst_bdata", rd_burst_d_o, 128'd0);
        chk("rst_misc",  {mem_addr_o, mem_wdata_o, rd_d_o, protocol_err_o, mem_we_o, mem_burst_o}, 59'd0);
        reset_i = 1'b0;
        tick();

        // ---- burst read at 0x000100 ----
        bq.push_back(24'h000100); drive_fifos();
        tick();
        chk("b_deq",   {burst_cmd_deq_o, cmd_deq_o}, 2'b10);
        chk("b_req",   {mem_req_o, mem_burst_o, mem_we_o}, 3'b110);
        chk("b_addr",  mem_addr_o, 24'h000100);
        chk("b_state", dbg_state_o, 4'd1);
        tick();
        chk("b_collect", dbg_state_o, 4'd2);
        chk("b_deq_1cy", burst_cmd_deq_o, 1'b0);
        for (int i = 1; i <= 8; i++) feed(16'h1111 * 16'(i));
        chk("b_enq",   rd_burst_enq_o, 1'b1);
        chk("b_data",  rd_burst_d_o, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        tick();
        chk("b_idle",  {dbg_state_o, rd_burst_enq_o}, 5'b0);
        chk("b_count", n_b_enq, 1);

        // ---- single write ----
        e0 = n_rd_enq;
        cq.push_back({1'b1, 24'h000042, 16'hBEEF}); drive_fifos();
        tick();
        chk("w_deq",   {cmd_deq_o, mem_req_o, mem_we_o, mem_burst_o}, 4'b1110);
        chk("w_addr",  mem_addr_o, 24'h000042);
        chk("w_data",  mem_wdata_o, 16'hBEEF);
        chk("w_state", dbg_state_o, 4'd4);
        tick();
        chk("w_idle",  {dbg_state_o, mem_req_o, mem_we_o}, 6'b0);
        tick(); tick();
        chk("w_no_rd", n_rd_enq - e0, 0);

        // ---- single read blocked by full reader FIFO ----
        rd_full_i = 1'b1;
        cq.push_back({1'b0, 24'h000010, 16'h0000}); drive_fifos();
        tick(); tick(); tick();
        chk("rf_blocked", {cmd_deq_o, mem_req_o, dbg_state_o}, 6'b0);
        rd_full_i = 1'b0;
        tick();
        chk("r_issue", {cmd_deq_o, mem_req_o, mem_we_o, dbg_state_o}, {3'b110, 4'd5});
        chk("r_addr",  mem_addr_o, 24'h000010);
        tick();
        chk("r_wait",  dbg_state_o, 4'd6);
        feed(16'h5A5A);
        chk("r_enq",   {rd_enq_o, rd_d_o}, {1'b1, 16'h5A5A});
        tick();
        chk("r_done",  {rd_enq_o, dbg_state_o}, 5'b0);
        chk("no_perr", n_perr, 0);

        // ---- stray read data in IDLE ----
        e0 = n_rd_enq; b0 = n_b_enq;
        feed(16'hDEAD);
        chk("s_perr",  protocol_err_o, 1'b1);
        tick();
        chk("s_pulse", protocol_err_o, 1'b0);
        chk("s_noenq", {32'(n_rd_enq - e0), 32'(n_b_enq - b0)}, 64'd0);

        // ---- both FIFOs loaded: 3 bursts + 1 write ----
        issue_log.delete();
        b0 = n_b_enq;
        bq.push_back(24'h000200); bq.push_back(24'h000208); bq.push_back(24'h000210);
        cq.push_back({1'b1, 24'h000055, 16'h1234});
        drive_fifos();
        auto_mem = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (issue_log.size() == 4 && dbg_state_o == 4'd0 && bq.size() == 0 && cq.size() == 0) break;
        end
        auto_mem = 1'b0; mem_rvalid_i = 1'b0;
        chk("o_count", issue_log.size(), 4);
        chk("o_benq",  n_b_enq - b0, 3);
        if (issue_log.size() == 4) begin
`ifdef FB_MEM_ARB_FAIR_EN
            chk("o_0", issue_log[0], {2'b01, 24'h000200});
            chk("o_1", issue_log[1], {2'b01, 24'h000208});
            chk("o_2", issue_log[2], {2'b10, 24'h000055});
            chk("o_3", issue_log[3], {2'b01, 24'h000210});
`else
            chk("o_0", issue_log[0], {2'b01, 24'h000200});
            chk("o_1", issue_log[1], {2'b01, 24'h000208});
            chk("o_2", issue_log[2], {2'b01, 24'h000210});
            chk("o_3", issue_log[3], {2'b10, 24'h000055});
`endif
        end
        tick();

        // ---- reset mid-burst after 3 words ----
        bq.push_back(24'h000300); drive_fifos();
        tick(); tick();
        chk("rb_collect", dbg_state_o, 4'd2);
        feed(16'hC001); feed(16'hC002); feed(16'hC003);
        reset_i = 1'b1;
        #1;
        chk("rb_state", dbg_state_o, 4'd0);
        chk("rb_bdata", rd_burst_d_o, 128'd0);
        chk("rb_outs",  {mem_req_o, mem_burst_o, mem_addr_o, burst_cmd_deq_o, protocol_err_o}, 28'd0);
        tick(); tick();
        reset_i = 1'b0;
        tick();
        feed(16'hBAD0);
        chk("rb_late_perr", protocol_err_o, 1'b1);
        tick();
        bq.push_back(24'h000400); drive_fifos();
        tick();
        chk("nb_addr", mem_addr_o, 24'h000400);
        tick();
        for (int i = 1; i <= 8; i++) feed(16'hA000 + 16'(i));
        chk("nb_enq",  rd_burst_enq_o, 1'b1);
        chk("nb_data", rd_burst_d_o, 128'hA001_A002_A003_A004_A005_A006_A007_A008);
        tick();
        chk("nb_idle", dbg_state_o, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
